// File: rtl/multi_timer_control.sv
// Multi-channel cook-timer controller: one FSM per channel, shared blink
// timebase, alarm auto-silence and LED multiplexing of the selected channel.
module multi_timer_control #(
  parameter int NCH          = 2,
  parameter int NLED         = 8,
  parameter int ALARM_BLINKS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] ch_sel,
  input  logic                cooktime_req,
  input  logic                start_timer,
  input  logic                timer_en,
  input  logic [NCH-1:0]      timer_done,
  input  logic                seconds_req,
  input  logic                minutes_req,
  input  logic                blink_pulse,
  input  logic [NCH*NLED-1:0] bargraph,
  output logic [NCH-1:0]      increment_seconds,
  output logic [NCH-1:0]      increment_minutes,
  output logic [NCH-1:0]      prog_mode,
  output logic [NCH-1:0]      main_timer_enable,
  output logic [NCH-1:0]      load_timer,
  output logic                timer_enabled_led,
  output logic                timer_on_led,
  output logic                alarm_active,
  output logic [NLED-1:0]     output_leds
);

  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int ACW = (ALARM_BLINKS > 1) ? $clog2(ALARM_BLINKS) : 1;
  localparam int ALIM = (ALARM_BLINKS > 0) ? ALARM_BLINKS - 1 : 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PROG  = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t         st_q   [NCH];
  state_t         st_d   [NCH];
  logic [ACW-1:0] acnt_q [NCH];
  logic [ACW-1:0] acnt_d [NCH];
  logic           flash_q, flash_d;
  logic [NCH-1:0] sel;
  logic [NCH-1:0] alarm_lim;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flash_q <= 1'b0;
      for (int unsigned k = 0; k < NCH; k++) begin
        st_q[k]   <= IDLE;
        acnt_q[k] <= '0;
      end
    end else begin
      flash_q <= flash_d;
      for (int unsigned k = 0; k < NCH; k++) begin
        st_q[k]   <= st_d[k];
        acnt_q[k] <= acnt_d[k];
      end
    end
  end

  always_comb begin
    flash_d   = flash_q ^ blink_pulse;
    sel       = '0;
    alarm_lim = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      sel[k]       = (ch_sel == CW'(k));
      alarm_lim[k] = (ALARM_BLINKS != 0) && blink_pulse && (acnt_q[k] == ACW'(ALIM));
      st_d[k]      = st_q[k];
      // Counter is held at zero outside DONE, so it is always clear on entry.
      if (ALARM_BLINKS != 0 && st_q[k] == DONE)
        acnt_d[k] = acnt_q[k] + ACW'(blink_pulse);
      else
        acnt_d[k] = '0;
      case (st_q[k])
        IDLE:  if (cooktime_req && sel[k]) st_d[k] = PROG;
        PROG:  if (start_timer && sel[k])  st_d[k] = LOAD;
        LOAD:  st_d[k] = RUN;
        RUN: begin
          if (cooktime_req && sel[k])     st_d[k] = PROG;
          else if (timer_done[k])         st_d[k] = DONE;
          else if (start_timer && sel[k]) st_d[k] = PAUSE;
        end
        PAUSE: begin
          if (cooktime_req && sel[k])     st_d[k] = PROG;
          else if (start_timer && sel[k]) st_d[k] = RUN;
        end
        DONE: begin
          if (cooktime_req && sel[k])     st_d[k] = PROG;
          else if (start_timer && sel[k]) st_d[k] = LOAD;
          else if (alarm_lim[k])          st_d[k] = IDLE;
        end
        default: st_d[k] = IDLE;
      endcase
    end
  end

  always_comb begin
    increment_seconds = '0;
    increment_minutes = '0;
    prog_mode         = '0;
    main_timer_enable = '0;
    load_timer        = '0;
    alarm_active      = 1'b0;
    output_leds       = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      prog_mode[k]         = (st_q[k] == PROG);
      load_timer[k]        = (st_q[k] == LOAD);
      main_timer_enable[k] = (st_q[k] == RUN) && timer_en;
      increment_seconds[k] = cooktime_req && seconds_req && sel[k] && (st_q[k] == PROG);
      increment_minutes[k] = cooktime_req && minutes_req && sel[k] && (st_q[k] == PROG);
      if (st_q[k] == DONE) alarm_active = 1'b1;
    end
    timer_enabled_led = |main_timer_enable;
    timer_on_led      = timer_enabled_led && flash_q;
    if (alarm_active) begin
      output_leds = {NLED{flash_q}};
    end else begin
      for (int unsigned k = 0; k < NCH; k++)
        if (sel[k] && (st_q[k] == RUN || st_q[k] == PAUSE))
          output_leds = bargraph[k*NLED +: NLED];
    end
  end

endmodule
